// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a multicycle MIPS-style datapath. Each instruction
//   starts in FETCH and walks a fixed state path selected by the opcode (and,
//   for R-type, by the function field). Opcode and function field are
//   registered in DECODE. Every output except pcen is a pure function of the
//   current state and these registered fields. pcen also depends on the live
//   ALU zero flag so that conditional branches resolve in their execute cycle.
//
//   Optional feature: define BYTE_LOAD_EN to decode LB/LBU and drive ltype.
//   When BYTE_LOAD_EN is undefined, LB/LBU are illegal opcodes and ltype is 00.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high; forces FETCH
//   op[5:0]     in   instruction opcode
//   funct[5:0]  in   R-type function field
//   zero        in   ALU zero flag
//   pcen        out  PC write enable (pcwrite or taken branch)
//   irwrite     out  instruction register write
//   regwrite    out  register file write
//   memwrite    out  memory write
//   iord        out  memory address select (1 = ALU out)
//   memtoreg    out  write-back data select (1 = memory)
//   regdst      out  destination register select (1 = rd)
//   alusrca     out  ALU A select (1 = register A)
//   illegal     out  one-cycle pulse on unknown opcode or function
//   alusrcb[2:0]     ALU B select
//   pcsrc[1:0]       next-PC select
//   alucontrol[2:0]  ALU operation
//   ltype[1:0]       load type: word / zero-ext byte / sign-ext byte
//   state[3:0]       current state, debug only
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction, PC <= PC + 4
// DECODE  | register operand read, branch target into ALU out
// MEMADR  | effective address = A + sext(imm)
// MEMRD   | memory read
// MEMWB   | memory data into rt
// MEMWR   | memory write
// REX     | R-type ALU operation
// RWB     | ALU result into rd
// IEX     | ADDI/SLTI with sign-extended immediate
// ZEX     | ANDI/ORI with zero-extended immediate
// IWB     | ALU result into rt
// BEQEX   | compare for BEQ, branch if zero
// BNEEX   | compare for BNE, branch if not zero
// JEX     | jump
// ERR     | illegal pulse, no writes, back to FETCH

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic       illegal,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [1:0] ltype,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_IEX    = 4'd8,
        S_ZEX    = 4'd9,
        S_IWB    = 4'd10,
        S_BEQEX  = 4'd11,
        S_BNEEX  = 4'd12,
        S_JEX    = 4'd13,
        S_ERR    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef BYTE_LOAD_EN
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic       pcwrite;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic [1:0] load_type;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    // R-type function decode from the registered field.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct_q)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        load_type = 2'b00;
`ifdef BYTE_LOAD_EN
        case (op_q)
            OP_LBU:  load_type = 2'b01;
            OP_LB:   load_type = 2'b10;
            default: load_type = 2'b00;
        endcase
`endif
    end

    always_comb begin
        state_d    = S_FETCH;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        illegal    = 1'b0;
        alusrcb    = 3'b000;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        ltype      = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 3'b001;
                alucontrol = ALU_ADD;
                pcwrite    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alusrcb    = 3'b011;
                alucontrol = ALU_ADD;
                // Next state uses the live opcode; it is registered on this edge.
                case (op)
                    OP_LW, OP_SW:       state_d = S_MEMADR;
`ifdef BYTE_LOAD_EN
                    OP_LB, OP_LBU:      state_d = S_MEMADR;
`endif
                    OP_RTYPE:           state_d = S_REX;
                    OP_BEQ:             state_d = S_BEQEX;
                    OP_BNE:             state_d = S_BNEEX;
                    OP_ADDI, OP_SLTI:   state_d = S_IEX;
                    OP_ANDI, OP_ORI:    state_d = S_ZEX;
                    OP_J:               state_d = S_JEX;
                    default:            state_d = S_ERR;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b010;
                alucontrol = ALU_ADD;
                state_d    = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                ltype   = load_type;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                ltype    = load_type;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_REX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = funct_ok ? S_RWB : S_ERR;
            end
            S_RWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEX: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b010;
                alucontrol = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d    = S_IWB;
            end
            S_ZEX: begin
                // Logical immediates still combine with register A.
                alusrca    = 1'b1;
                alusrcb    = 3'b100;
                alucontrol = (op_q == OP_ORI) ? ALU_OR : ALU_AND;
                state_d    = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_ERR: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pcen  = pcwrite
                 | ((state_q == S_BEQEX) &  zero)
                 | ((state_q == S_BNEEX) & ~zero);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [2:0] alusrcb, alucontrol;
    logic [1:0] pcsrc, ltype;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .illegal(illegal), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .ltype(ltype), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, illegal;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic [1:0] ltype;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                    illegal, alusrcb, pcsrc, alucontrol, ltype};

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction classes used by the reference model.
    localparam int C_LOAD = 0, C_STORE = 1, C_RT = 2, C_IMM = 3, C_ZIMM = 4,
                   C_BEQ = 5, C_BNE = 6, C_JMP = 7, C_BAD = 8;

    function automatic int classify(input logic [5:0] o);
        case (o)
            6'b100011: return C_LOAD;
`ifdef BYTE_LOAD_EN
            6'b100000, 6'b100100: return C_LOAD;
`endif
            6'b101011: return C_STORE;
            6'b000000: return C_RT;
            6'b001000, 6'b001010: return C_IMM;
            6'b001100, 6'b001101: return C_ZIMM;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b000010: return C_JMP;
            default:   return C_BAD;
        endcase
    endfunction

    function automatic int instr_len(input logic [5:0] o);
        case (classify(o))
            C_LOAD:                return 5;
            C_STORE, C_RT, C_IMM, C_ZIMM: return 4;
            default:               return 3;
        endcase
    endfunction

    // Returns {ok, alu code} for a function field.
    function automatic logic [3:0] funct_code(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_010;
        endcase
    endfunction

    function automatic logic [1:0] load_kind(input logic [5:0] o);
`ifdef BYTE_LOAD_EN
        if (o == 6'b100100) return 2'b01;
        if (o == 6'b100000) return 2'b10;
`endif
        return 2'b00;
    endfunction

    // Expected outputs for cycle 'step' (0 = fetch) of an instruction.
    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f,
                                    input logic z, input int step);
        outs_t e = '0;
        int    c = classify(o);
        logic [3:0] fc = funct_code(f);
        if (step == 0) begin
            e.irwrite = 1; e.alusrcb = 3'b001; e.alucontrol = 3'b010; e.pcen = 1;
        end else if (step == 1) begin
            e.alusrcb = 3'b011; e.alucontrol = 3'b010;
        end else if (c == C_LOAD || c == C_STORE) begin
            if (step == 2) begin
                e.alusrca = 1; e.alusrcb = 3'b010; e.alucontrol = 3'b010;
            end else if (c == C_STORE) begin
                e.iord = 1; e.memwrite = 1;
            end else if (step == 3) begin
                e.iord = 1; e.ltype = load_kind(o);
            end else begin
                e.memtoreg = 1; e.regwrite = 1; e.ltype = load_kind(o);
            end
        end else if (c == C_RT) begin
            if (step == 2) begin
                e.alusrca = 1; e.alucontrol = fc[2:0];
            end else if (fc[3]) begin
                e.regdst = 1; e.regwrite = 1;
            end else begin
                e.illegal = 1;
            end
        end else if (c == C_IMM || c == C_ZIMM) begin
            if (step == 2) begin
                e.alusrca = 1;
                if (c == C_IMM) begin
                    e.alusrcb = 3'b010; e.alucontrol = (o == 6'b001010) ? 3'b111 : 3'b010;
                end else begin
                    e.alusrcb = 3'b100; e.alucontrol = (o == 6'b001101) ? 3'b001 : 3'b000;
                end
            end else begin
                e.regwrite = 1;
            end
        end else if (c == C_BEQ || c == C_BNE) begin
            e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
            e.pcen = (c == C_BEQ) ? z : ~z;
        end else if (c == C_JMP) begin
            e.pcsrc = 2'b10; e.pcen = 1;
        end else begin
            e.illegal = 1;
        end
        return e;
    endfunction

    logic       chk_en = 1'b0;
    logic [5:0] cur_op = '0, cur_funct = '0;
    logic       cur_zero = 1'b0;
    int         cur_step = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("model op=%b fn=%b z=%0d step%0d", cur_op, cur_funct, cur_zero, cur_step),
                  32'(dut_o), 32'(model(cur_op, cur_funct, cur_zero, cur_step)));
            check($sformatf("fetch_state op=%b step%0d", cur_op, cur_step),
                  32'(state == 4'd0), 32'(cur_step == 0));
        end
    end

    outs_t snap [0:7];

    // Starts in FETCH just after a clock edge; returns in FETCH just after an edge.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z);
        int n = instr_len(o);
        op = o; funct = f; zero = z;
        cur_op = o; cur_funct = f; cur_zero = z;
        for (int s = 0; s < n; s++) begin
            cur_step = s;
            chk_en   = 1'b1;
            @(negedge clk);
            #1 snap[s] = dut_o;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        #8;
        check("reset_state", 32'(state), 32'd0);
        check("reset_regwrite", 32'(regwrite), 32'd0);
        check("reset_memwrite", 32'(memwrite), 32'd0);
        check("reset_irwrite", 32'(irwrite), 32'd1);
        check("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run(6'b100011, 6'b000000, 1'b0);                  // LW
        check("lw_wb_regwrite", 32'(snap[4].regwrite), 32'd1);
        check("lw_wb_memtoreg", 32'(snap[4].memtoreg), 32'd1);
        check("lw_rd_regwrite", 32'(snap[3].regwrite), 32'd0);
        check("lw_done_fetch", 32'(state), 32'd0);

        run(6'b101011, 6'b000000, 1'b1);                  // SW
        run(6'b000000, 6'b100000, 1'b0);                  // add
        run(6'b000000, 6'b100010, 1'b1);                  // sub
        run(6'b000000, 6'b100100, 1'b0);                  // and
        run(6'b000000, 6'b100101, 1'b0);                  // or
        run(6'b000000, 6'b101010, 1'b0);                  // slt
        check("slt_alucontrol", 32'(snap[2].alucontrol), 32'h7);
        check("slt_rwb_regdst", 32'(snap[3].regdst), 32'd1);
        check("slt_rwb_regwrite", 32'(snap[3].regwrite), 32'd1);
        run(6'b000000, 6'b111111, 1'b0);                  // bad funct
        check("badfn_illegal", 32'(snap[3].illegal), 32'd1);
        check("badfn_regwrite", 32'(snap[3].regwrite), 32'd0);

        run(6'b001000, 6'b000000, 1'b0);                  // ADDI
        run(6'b001010, 6'b000000, 1'b0);                  // SLTI
        run(6'b001100, 6'b000000, 1'b0);                  // ANDI
        run(6'b001101, 6'b000000, 1'b0);                  // ORI
        check("ori_alusrcb", 32'(snap[2].alusrcb), 32'h4);
        check("ori_alucontrol", 32'(snap[2].alucontrol), 32'h1);
        check("ori_iwb_regwrite", 32'(snap[3].regwrite), 32'd1);

        run(6'b000100, 6'b000000, 1'b1);                  // BEQ taken
        check("beq_z1_pcen", 32'(snap[2].pcen), 32'd1);
        check("beq_z1_pcsrc", 32'(snap[2].pcsrc), 32'h1);
        run(6'b000100, 6'b000000, 1'b0);                  // BEQ not taken
        run(6'b000101, 6'b000000, 1'b1);                  // BNE not taken
        check("bne_z1_pcen", 32'(snap[2].pcen), 32'd0);
        run(6'b000101, 6'b000000, 1'b0);                  // BNE taken
        run(6'b000010, 6'b000000, 1'b0);                  // J

        run(6'b111111, 6'b000000, 1'b0);                  // unknown op
        check("badop_illegal", 32'(snap[2].illegal), 32'd1);
        check("badop_writes", 32'({snap[2].regwrite, snap[2].memwrite}), 32'd0);
        check("badop_next_fetch", 32'(state), 32'd0);

        run(6'b100000, 6'b000000, 1'b0);                  // LB
`ifdef BYTE_LOAD_EN
        check("lb_ltype", 32'(snap[4].ltype), 32'h2);
`else
        check("lb_illegal", 32'(snap[2].illegal), 32'd1);
        check("lb_writes", 32'({snap[2].regwrite, snap[2].memwrite}), 32'd0);
`endif
        run(6'b100100, 6'b000000, 1'b0);                  // LBU

        // Reset in the middle of a store's write cycle.
        op = 6'b101011; funct = '0; zero = 1'b0;
        cur_op = op; cur_funct = funct; cur_zero = zero;
        for (int s = 0; s < 4; s++) begin
            cur_step = s;
            chk_en   = 1'b1;
            @(negedge clk);
            if (s < 3) begin
                @(posedge clk);
                #1;
            end
        end
        chk_en = 1'b0;
        #1 check("sw_memwrite_before_reset", 32'(memwrite), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_memwrite", 32'(memwrite), 32'd0);
        check("abort_regwrite", 32'(regwrite), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("release_state", 32'(state), 32'd0);
        run(6'b100011, 6'b000000, 1'b1);                  // LW after release

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
